// File: rtl/memory_responder_pkg.sv
// Shared types, widths and address-check helper for the memory responder slice.
package memory_responder_pkg;

  localparam int DATA_W         = 32;
  localparam int CNT_W          = 4;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_LATENCY    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // A byte address is unusable if it is not word aligned or lies beyond the array.
  function automatic logic addr_err(input logic [31:0] addr, input int addr_width);
    logic [31:0] upper;
    upper = addr >> (addr_width + 2);
    return (addr[1:0] != 2'b00) || (upper != 32'd0);
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/response channel between a CPU memory port (master) and the responder (slave).
interface memory_responder_if;
  import memory_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/memory_responder_word_ram.sv
// Single-port word RAM: shared address, synchronous write, registered read.
module memory_responder_word_ram
  import memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read data only moves on a read access, so it holds for the whole response.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Memory responder: one outstanding word request, serviced against a single-port
// RAM after a fixed latency, response held until the initiator accepts it.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input logic               clk,
  input logic               reset,
  memory_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic                  req_ready_q;
  logic                  accept;
  logic                  commit;

  logic                  we_p0;
  logic                  err_p0;
  logic [ADDR_WIDTH-1:0] idx_p0;
  logic [DATA_W-1:0]     wdata_p0;

  logic                  vld_p1;
  logic                  err_p1;
  logic                  rd_ok_p1;
  logic [DATA_W-1:0]     ram_q;

  assign accept = req_ready_q && bus.req_valid;
  // Gated by reset so a write whose commit edge coincides with reset is dropped.
  assign commit = (state == ST_WAIT) && (cnt == CNT_LAST) && !reset;

  // Stage p0: request capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      err_p0   <= addr_err(bus.req_addr, ADDR_WIDTH);
      idx_p0   <= bus.req_addr[ADDR_WIDTH+1:2];
      wdata_p0 <= bus.req_wdata;
    end
  end

  // WAIT lasts LATENCY cycles for every legal LATENCY (1 included), so the
  // response appears exactly LATENCY edges after the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      vld_p1      <= 1'b0;
      err_p1      <= 1'b0;
      rd_ok_p1    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_WAIT;
            cnt         <= '0;
            req_ready_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_LAST) begin
            state    <= ST_RESP;
            vld_p1   <= 1'b1;
            err_p1   <= err_p0;
            rd_ok_p1 <= !we_p0 && !err_p0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
            vld_p1      <= 1'b0;
            err_p1      <= 1'b0;
            rd_ok_p1    <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          cnt         <= '0;
          req_ready_q <= 1'b1;
          vld_p1      <= 1'b0;
          err_p1      <= 1'b0;
          rd_ok_p1    <= 1'b0;
        end
      endcase
    end
  end

  memory_responder_word_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_word_ram (
    .clk   (clk),
    .en    (commit && !err_p0),
    .we    (we_p0),
    .addr  (idx_p0),
    .wdata (wdata_p0),
    .rdata (ram_q)
  );

  // Stage p1: response outputs; data is zero for writes, errors and when idle
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = vld_p1;
  assign bus.resp_err   = err_p1;
  assign bus.resp_data  = rd_ok_p1 ? ram_q : '0;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed and randomized transactions on a LATENCY=2
// instance plus back-to-back traffic on a LATENCY=1 instance, against a word-array model.
module tb_memory_responder;

  localparam int AW = 10;
  localparam int L0 = 2;
  localparam int L1 = 1;
  localparam int NB = 18;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  memory_responder_if if0 ();
  memory_responder_if if1 ();

  memory_responder #(.ADDR_WIDTH(AW), .LATENCY(L0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  memory_responder #(.ADDR_WIDTH(AW), .LATENCY(L1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  int checks = 0;
  int errors = 0;

  logic [31:0] model0 [int];
  logic [31:0] model1 [int];

  int          t_wait, t_lat, t_chg, t_rdy;
  logic [31:0] t_data;
  logic        t_err, t_vld_after, t_rdy_after;

  function automatic bit is_err(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= (32'd4 << AW));
  endfunction

  function void mem0_write(input logic [31:0] a, input logic [31:0] d);
    if (!is_err(a)) model0[int'(a >> 2)] = d;
  endfunction

  function logic [31:0] mem0_read(input logic [31:0] a);
    if (is_err(a)) return 32'd0;
    if (model0.exists(int'(a >> 2))) return model0[int'(a >> 2)];
    return 32'd0;
  endfunction

  // One transaction on the LATENCY=2 instance; observations land in t_*.
  task automatic do_txn0(input logic [31:0] a, input logic we, input logic [31:0] d, input int hold);
    t_wait = 0; t_lat = -1; t_chg = 0; t_rdy = 0;
    t_data = '0; t_err = 1'b0; t_vld_after = 1'b1; t_rdy_after = 1'b0;
    if0.req_valid = 1'b1; if0.req_addr = a; if0.req_we = we; if0.req_wdata = d;
    @(negedge clk);
    while (if0.req_ready !== 1'b1 && t_wait < 50) begin
      t_wait++;
      @(negedge clk);
    end
    if (t_wait >= 50) begin
      if0.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Keep a junk request on the bus: it must be ignored until IDLE again.
    if0.req_addr = $urandom; if0.req_we = 1'($urandom); if0.req_wdata = $urandom;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (if0.req_ready !== 1'b0) t_rdy++;
      if (if0.resp_valid === 1'b1) begin
        t_lat = k;
        break;
      end
    end
    if (t_lat < 0) begin
      if0.req_valid = 1'b0;
      return;
    end
    t_data = if0.resp_data;
    t_err  = if0.resp_err;
    for (int h = 0; h < hold; h++) begin
      if0.req_addr = $urandom; if0.req_we = 1'($urandom); if0.req_wdata = $urandom;
      @(posedge clk); #1;
      if (if0.resp_valid !== 1'b1 || if0.resp_data !== t_data || if0.resp_err !== t_err) t_chg++;
      if (if0.req_ready !== 1'b0) t_rdy++;
    end
    if0.resp_ready = 1'b1;
    @(posedge clk); #1;
    if0.resp_ready = 1'b0;
    if0.req_valid  = 1'b0;
    t_vld_after = if0.resp_valid;
    t_rdy_after = if0.req_ready;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL rst0_req_ready: got %b, want 1", if0.req_ready); end
    checks++; if (if0.resp_valid !== 1'b0) begin errors++; $display("FAIL rst0_resp_valid: got %b, want 0", if0.resp_valid); end
    checks++; if (if0.resp_data !== 32'd0) begin errors++; $display("FAIL rst0_resp_data: got %h, want 0", if0.resp_data); end
    checks++; if (if0.resp_err !== 1'b0) begin errors++; $display("FAIL rst0_resp_err: got %b, want 0", if0.resp_err); end
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL rst1_req_ready: got %b, want 1", if1.req_ready); end
    checks++; if (if1.resp_valid !== 1'b0) begin errors++; $display("FAIL rst1_resp_valid: got %b, want 0", if1.resp_valid); end
    checks++; if (if1.resp_data !== 32'd0) begin errors++; $display("FAIL rst1_resp_data: got %h, want 0", if1.resp_data); end
    checks++; if (if1.resp_err !== 1'b0) begin errors++; $display("FAIL rst1_resp_err: got %b, want 0", if1.resp_err); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    do_txn0(32'h10, 1'b1, 32'hDEADBEEF, 0);
    mem0_write(32'h10, 32'hDEADBEEF);
    checks++; if (t_wait !== 0) begin errors++; $display("FAIL wr_accept_wait: got %0d, want 0", t_wait); end
    checks++; if (t_lat !== L0) begin errors++; $display("FAIL wr_latency: got %0d, want %0d", t_lat, L0); end
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b, want 0", t_err); end
    checks++; if (t_data !== 32'd0) begin errors++; $display("FAIL wr_data: got %h, want 0", t_data); end
    checks++; if (t_rdy_after !== 1'b1) begin errors++; $display("FAIL wr_idle_after: got %b, want 1", t_rdy_after); end
    do_txn0(32'h10, 1'b0, 32'h0, 0);
    checks++; if (t_wait !== 0) begin errors++; $display("FAIL rd_accept_wait: got %0d, want 0", t_wait); end
    checks++; if (t_lat !== L0) begin errors++; $display("FAIL rd_latency: got %0d, want %0d", t_lat, L0); end
    checks++; if (t_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h, want deadbeef", t_data); end
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b, want 0", t_err); end
    checks++; if (t_vld_after !== 1'b0) begin errors++; $display("FAIL rd_valid_after: got %b, want 0", t_vld_after); end
  endtask

  task automatic test_errors();
    logic [31:0] ta [10] = '{32'h0, 32'h12, 32'h10, 32'h1000, 32'h1000, 32'h13,
                             32'h8000_0010, 32'h0, 32'h10, 32'hFFC};
    logic        tw [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] td [10] = '{32'hA5A5_0000, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678,
                             32'h0BAD_0BAD, 32'h0, 32'h0, 32'h0};
    logic [31:0] exp_d;
    logic        exp_e;
    mem0_write(32'hFFC, 32'h7777_1111);
    do_txn0(32'hFFC, 1'b1, 32'h7777_1111, 0);
    for (int i = 0; i < 10; i++) begin
      exp_e = is_err(ta[i]);
      exp_d = tw[i] ? 32'd0 : mem0_read(ta[i]);
      do_txn0(ta[i], tw[i], td[i], 0);
      if (tw[i]) mem0_write(ta[i], td[i]);
      checks++; if (t_lat !== L0) begin errors++; $display("FAIL err_tbl%0d_latency: got %0d, want %0d", i, t_lat, L0); end
      checks++; if (t_err !== exp_e) begin errors++; $display("FAIL err_tbl%0d_err: got %b, want %b", i, t_err, exp_e); end
      checks++; if (t_data !== exp_d) begin errors++; $display("FAIL err_tbl%0d_data: got %h, want %h", i, t_data, exp_d); end
    end
  endtask

  task automatic test_backpressure();
    do_txn0(32'h10, 1'b0, 32'h0, 5);
    checks++; if (t_lat !== L0) begin errors++; $display("FAIL bp_latency: got %0d, want %0d", t_lat, L0); end
    checks++; if (t_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_data: got %h, want deadbeef", t_data); end
    checks++; if (t_chg !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes, want 0", t_chg); end
    checks++; if (t_rdy !== 0) begin errors++; $display("FAIL bp_req_ready_low: got %0d high cycles, want 0", t_rdy); end
    checks++; if (t_vld_after !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b, want 0", t_vld_after); end
    checks++; if (t_rdy_after !== 1'b1) begin errors++; $display("FAIL bp_idle_after: got %b, want 1", t_rdy_after); end
  endtask

  task automatic test_reset_mid();
    do_txn0(32'h20, 1'b1, 32'h1111_1111, 0);
    mem0_write(32'h20, 32'h1111_1111);
    if0.req_valid = 1'b1; if0.req_addr = 32'h20; if0.req_we = 1'b1; if0.req_wdata = 32'h55;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (if0.req_ready !== 1'b0) begin errors++; $display("FAIL mid_busy: req_ready got %b, want 0", if0.req_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_req_ready: got %b, want 1", if0.req_ready); end
    checks++; if (if0.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_resp_valid: got %b, want 0", if0.resp_valid); end
    checks++; if (if0.resp_data !== 32'd0) begin errors++; $display("FAIL mid_rst_resp_data: got %h, want 0", if0.resp_data); end
    checks++; if (if0.resp_err !== 1'b0) begin errors++; $display("FAIL mid_rst_resp_err: got %b, want 0", if0.resp_err); end
    do_txn0(32'h20, 1'b0, 32'h0, 0);
    checks++; if (t_data !== 32'h1111_1111) begin errors++; $display("FAIL mid_dropped_write: got %h, want 11111111", t_data); end
    checks++; if (t_lat !== L0) begin errors++; $display("FAIL mid_read_latency: got %0d, want %0d", t_lat, L0); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp_d;
    logic        we, exp_e;
    int          hold;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_txn0(32'h100 + 32'(4 * i), 1'b1, d, 0);
      mem0_write(32'h100 + 32'(4 * i), d);
      checks++; if (t_lat !== L0 || t_err !== 1'b0) begin errors++; $display("FAIL rnd_fill%0d: lat %0d err %b, want %0d 0", i, t_lat, t_err, L0); end
    end
    for (int i = 0; i < 40; i++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = a + 32'h1000;
        2: a = a | 32'h4000_0000;
        default: ;
      endcase
      we   = 1'($urandom);
      d    = $urandom;
      hold = $urandom_range(0, 3);
      exp_e = is_err(a);
      exp_d = we ? 32'd0 : mem0_read(a);
      do_txn0(a, we, d, hold);
      if (we) mem0_write(a, d);
      checks++; if (t_lat !== L0) begin errors++; $display("FAIL rnd%0d_latency: got %0d, want %0d", i, t_lat, L0); end
      checks++; if (t_err !== exp_e) begin errors++; $display("FAIL rnd%0d_err addr %h: got %b, want %b", i, a, t_err, exp_e); end
      checks++; if (t_data !== exp_d) begin errors++; $display("FAIL rnd%0d_data addr %h: got %h, want %h", i, a, t_data, exp_d); end
      checks++; if (t_chg !== 0 || t_rdy !== 0) begin errors++; $display("FAIL rnd%0d_hold: changes %0d ready-high %0d, want 0 0", i, t_chg, t_rdy); end
      checks++; if (t_vld_after !== 1'b0 || t_rdy_after !== 1'b1) begin errors++; $display("FAIL rnd%0d_idle_after: valid %b ready %b, want 0 1", i, t_vld_after, t_rdy_after); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba [NB];
    logic        bw [NB];
    logic [31:0] bd [NB];
    logic [31:0] ed [NB];
    logic        ee [NB];
    int          acc [NB];
    int          na, nr, last_acc, idx;
    logic        rdy, exp_vld;
    for (int i = 0; i < NB; i++) begin
      if (i < 6) begin
        ba[i] = 32'h200 + 32'(4 * i);
        bw[i] = 1'b1;
      end else begin
        ba[i] = 32'h200 + 32'(4 * $urandom_range(0, 5));
        case ($urandom_range(0, 6))
          0: ba[i] = ba[i] | 32'h2;
          1: ba[i] = ba[i] + 32'h1000;
          default: ;
        endcase
        bw[i] = 1'($urandom);
      end
      bd[i] = $urandom;
      ee[i] = is_err(ba[i]);
      idx   = int'(ba[i] >> 2);
      ed[i] = (!bw[i] && !ee[i]) ? model1[idx] : 32'd0;
      if (bw[i] && !ee[i]) model1[idx] = bd[i];
    end
    if1.resp_ready = 1'b1;
    @(posedge clk); #1;
    na = 0; nr = 0; last_acc = -10;
    if1.req_valid = 1'b1; if1.req_addr = ba[0]; if1.req_we = bw[0]; if1.req_wdata = bd[0];
    for (int cyc = 0; cyc < 150 && nr < NB; cyc++) begin
      @(negedge clk);
      rdy = if1.req_ready;
      @(posedge clk); #1;
      exp_vld = (last_acc == cyc - 1);
      if (rdy && na < NB) begin
        acc[na] = cyc;
        last_acc = cyc;
        na++;
        if (na < NB) begin
          if1.req_addr = ba[na]; if1.req_we = bw[na]; if1.req_wdata = bd[na];
        end else begin
          if1.req_valid = 1'b0;
        end
      end
      checks++; if (if1.resp_valid !== exp_vld) begin errors++; $display("FAIL b2b_valid cyc %0d: got %b, want %b", cyc, if1.resp_valid, exp_vld); end
      if (if1.resp_valid === 1'b1 && nr < NB) begin
        checks++; if (if1.resp_data !== ed[nr] || if1.resp_err !== ee[nr]) begin
          errors++; $display("FAIL b2b_resp%0d addr %h: got data %h err %b, want %h %b", nr, ba[nr], if1.resp_data, if1.resp_err, ed[nr], ee[nr]);
        end
        nr++;
      end
    end
    if1.resp_ready = 1'b0;
    if1.req_valid  = 1'b0;
    checks++; if (nr !== NB) begin errors++; $display("FAIL b2b_resp_count: got %0d, want %0d", nr, NB); end
    checks++; if (na !== NB) begin errors++; $display("FAIL b2b_accept_count: got %0d, want %0d", na, NB); end
    for (int i = 1; i < na; i++) begin
      checks++; if (acc[i] - acc[i-1] !== 3) begin errors++; $display("FAIL b2b_spacing%0d: got %0d, want 3", i, acc[i] - acc[i-1]); end
    end
  endtask

  initial begin
    if0.req_valid = 1'b0; if0.req_addr = '0; if0.req_we = 1'b0; if0.req_wdata = '0; if0.resp_ready = 1'b0;
    if1.req_valid = 1'b0; if1.req_addr = '0; if1.req_we = 1'b0; if1.req_wdata = '0; if1.resp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
